// File: rtl/exec_wb_buffer_if.sv
// rtl/exec_wb_buffer_if.sv - execution result / register-file writeback / forwarding bus
interface exec_wb_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [REG_AW-1:0]     ex_rd;
  logic [DATA_WIDTH-1:0] ex_result;
  logic                  rf_we;
  logic [REG_AW-1:0]     rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  wb_grant;
  logic [REG_AW-1:0]     fwd_rs;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [CW-1:0]         count;

  modport master (
    output ex_valid, ex_rd, ex_result, wb_grant, fwd_rs,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, count
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, wb_grant, fwd_rs,
    output ex_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/exec_wb_buffer.sv
// rtl/exec_wb_buffer.sv - in-order writeback FIFO with newest-wins forwarding lookup
module exec_wb_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 4
) (
  input logic            clk,
  input logic            reset,
  exec_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0]     ent_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         occ;
  logic                  push;
  logic                  store;
  logic                  pop;

  // Readiness depends only on occupancy, so a full buffer never pushes through.
  assign bus.ex_ready = (occ != CW'(DEPTH));
  assign bus.rf_we    = (occ != '0);
  assign bus.count    = occ;

  // Writes to x0 complete the handshake but are discarded.
  assign push  = bus.ex_valid && bus.ex_ready;
  assign store = push && (bus.ex_rd != '0);
  assign pop   = bus.rf_we && bus.wb_grant;

  assign bus.rf_waddr = bus.rf_we ? ent_rd[rptr]   : '0;
  assign bus.rf_wdata = bus.rf_we ? ent_data[rptr] : '0;

  // Pointer and occupancy bookkeeping; reset overrides any push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (store) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({store, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (store) begin
      ent_rd[wptr]   <= bus.ex_rd;
      ent_data[wptr] <= bus.ex_result;
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if ((CW'(i) < occ) && (bus.fwd_rs != '0) && (ent_rd[idx] == bus.fwd_rs)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = ent_data[idx];
      end
    end
  end
endmodule
